// File: rtl/alu_seq_ctrl.sv
// Pushbutton-driven ALU sequencer. Each button is synchronized, debounced and
// edge-detected; a small FSM captures A, B and opcode, then executes one op.
module alu_seq_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int DBNC_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_A_button,
  input  logic               i_B_button,
  input  logic               i_OP_button,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_zero,
  output logic               o_valid,
  output logic               o_err,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [7:0]       CNT_LAST = 8'(DBNC_CYCLES - 1);

  // Button index 0 = A, 1 = B, 2 = OP.
  logic [2:0] btn_raw_s;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] lvl_q, lvl_d, lvl_dly_q, evt_q, evt_d;
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic               valid_q, valid_d, err_q, err_d;

  logic [NB_DATA:0]   sum_s;
  logic [NB_DATA-1:0] alu_res_s;
  logic               alu_c_s, alu_v_s, alu_err_s, shift_big_s;

  always_comb begin
    btn_raw_s = {i_OP_button, i_B_button, i_A_button};
    lvl_d     = lvl_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
    end
    // Event is registered one cycle after the debounced level rises.
    evt_d = lvl_q & ~lvl_dly_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      lvl_q     <= 3'b000;
      lvl_dly_q <= 3'b000;
      evt_q     <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q   <= btn_raw_s;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      evt_q     <= evt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    sum_s       = {1'b0, a_q} + {1'b0, b_q};
    shift_big_s = (b_q >= NB_DATA'(NB_DATA));
    alu_res_s   = '0;
    alu_c_s     = 1'b0;
    alu_v_s     = 1'b0;
    alu_err_s   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res_s = sum_s[NB_DATA-1:0];
        alu_c_s   = sum_s[NB_DATA];
        alu_v_s   = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) &&
                    (sum_s[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res_s = a_q - b_q;
        alu_c_s   = (a_q < b_q);
        alu_v_s   = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) &&
                    (alu_res_s[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_AND: alu_res_s = a_q & b_q;
      OP_OR:  alu_res_s = a_q | b_q;
      OP_XOR: alu_res_s = a_q ^ b_q;
      OP_NOR: alu_res_s = ~(a_q | b_q);
      OP_SRL: begin
        if (shift_big_s) alu_res_s = '0;
        else             alu_res_s = a_q >> b_q;
      end
      OP_SRA: begin
        if (shift_big_s) alu_res_s = {NB_DATA{a_q[NB_DATA-1]}};
        else             alu_res_s = NB_DATA'($signed(a_q) >>> b_q);
      end
      default: alu_err_s = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    case (state_q)
      S_WAIT_A: begin
        if (evt_q[0]) begin
          a_d     = i_data;
          state_d = S_WAIT_B;
        end else begin
          state_d = S_WAIT_A;
        end
      end
      S_WAIT_B: begin
        if (evt_q[1]) begin
          b_d     = i_data;
          state_d = S_WAIT_OP;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_OP: begin
        if (evt_q[2]) begin
          op_d    = i_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else begin
          state_d = S_WAIT_OP;
        end
      end
      S_EXEC: begin
        result_d = alu_res_s;
        carry_d  = alu_c_s;
        ovf_d    = alu_v_s;
        zero_d   = (alu_res_s == '0);
        err_d    = alu_err_s;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // Re-execute with a single new field; A restarts the sequence.
        if (evt_q[0]) begin
          a_d     = i_data;
          state_d = S_WAIT_B;
        end else if (evt_q[1]) begin
          b_d     = i_data;
          state_d = S_EXEC;
        end else if (evt_q[2]) begin
          op_d    = i_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_result   = result_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: table of full A/B/OP sequences plus
// hand-written corner sequences, results matched through a scoreboard queue.
module tb_alu_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic [2:0] btn;
  logic [7:0] o_result;
  logic       o_carry, o_overflow, o_zero, o_valid, o_err;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int push_count = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       e;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    exp_t       exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  alu_seq_ctrl #(.NB_DATA(8), .NB_OP(6), .DBNC_CYCLES(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data),
    .i_A_button(btn[0]), .i_B_button(btn[1]), .i_OP_button(btn[2]),
    .o_result(o_result), .o_carry(o_carry), .o_overflow(o_overflow),
    .o_zero(o_zero), .o_valid(o_valid), .o_err(o_err), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every o_valid pulse must match the oldest pending expectation.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      valid_count++;
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", {24'd0, o_result}, {24'd0, e.res});
        chk("flags_cvze", {28'd0, o_carry, o_overflow, o_zero, o_err},
            {28'd0, e.c, e.v, e.z, e.e});
      end
    end
  end

  task automatic press(input int idx, input logic [7:0] d, input bit push, input exp_t e);
    @(negedge i_clk);
    i_data = d;
    if (push) begin
      sb_q.push_back(e);
      push_count++;
    end
    btn[idx] = 1'b1;
    repeat (12) @(negedge i_clk);
    btn[idx] = 1'b0;
    repeat (10) @(negedge i_clk);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t none;
    none = '0;
    press(0, v.a, 1'b0, none);
    press(1, v.b, 1'b0, none);
    press(2, {2'b00, v.op}, 1'b1, v.exp);
    chk("state_done", {29'd0, o_state}, 32'd4);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    exp_t none;
    exp_t e;
    int   waited;
    none = '0;

    //         a      b      op          res    c     v     z     e
    vecs[0]  = '{8'h7F, 8'h01, 6'b100000, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{8'h05, 8'h07, 6'b100010, '{8'hFE, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{8'h90, 8'h09, 6'b000011, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{8'hF0, 8'h0F, 6'b100100, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{8'hF0, 8'h0F, 6'b100101, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{8'hAA, 8'hFF, 6'b100110, '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{8'h0F, 8'hF0, 6'b100111, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[7]  = '{8'h80, 8'h07, 6'b000010, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{8'h80, 8'h07, 6'b000011, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{8'hFF, 8'h01, 6'b100000, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{8'h80, 8'h01, 6'b100010, '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[11] = '{8'h80, 8'h08, 6'b000010, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[12] = '{8'h3C, 8'h01, 6'b111111, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[13] = '{8'h12, 8'h34, 6'b100000, '{8'h46, 1'b0, 1'b0, 1'b0, 1'b0}};

    i_reset = 1'b1;
    i_data  = 8'h00;
    btn     = 3'b000;
    repeat (3) @(negedge i_clk);
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_result", {24'd0, o_result}, 32'd0);
    chk("rst_flags", {27'd0, o_carry, o_overflow, o_zero, o_valid, o_err}, 32'd0);
    i_reset = 1'b0;

    // B press while waiting for A must be ignored.
    press(1, 8'h55, 1'b0, none);
    chk("b_ignored_state", {29'd0, o_state}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // SUB then re-execute from DONE with a new B.
    run_vec('{8'h05, 8'h07, 6'b100010, '{8'hFE, 1'b1, 1'b0, 1'b0, 1'b0}});
    press(1, 8'h05, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("done_b_state", {29'd0, o_state}, 32'd4);

    // SRA then switch opcode to SRL from DONE.
    run_vec('{8'h90, 8'h09, 6'b000011, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}});
    press(2, 8'h02, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    // Bouncing A button: only the final stable level may capture.
    do_reset();
    @(negedge i_clk);
    i_data = 8'h11;
    for (int i = 0; i < 20; i++) begin
      btn[0] = ~btn[0];
      @(negedge i_clk);
    end
    chk("bounce_no_capture", {29'd0, o_state}, 32'd0);
    btn[0] = 1'b1;
    repeat (12) @(negedge i_clk);
    chk("bounce_one_capture", {29'd0, o_state}, 32'd1);
    btn[0] = 1'b0;
    repeat (10) @(negedge i_clk);
    press(1, 8'h22, 1'b0, none);
    press(2, 8'h20, 1'b1, '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset while in EXEC aborts the operation without a valid pulse.
    do_reset();
    press(0, 8'h01, 1'b0, none);
    press(1, 8'h02, 1'b0, none);
    @(negedge i_clk);
    i_data = 8'h20;
    btn[2] = 1'b1;
    waited = 0;
    while (o_state !== 3'd3 && waited < 40) begin
      @(negedge i_clk);
      waited++;
    end
    chk("exec_reached", {29'd0, o_state}, 32'd3);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("abort_valid", {31'd0, o_valid}, 32'd0);
    chk("abort_result", {24'd0, o_result}, 32'd0);
    chk("abort_state", {29'd0, o_state}, 32'd0);
    i_reset = 1'b0;
    btn[2] = 1'b0;
    repeat (15) @(negedge i_clk);
    chk("abort_idle", {29'd0, o_state}, 32'd0);

    repeat (5) @(negedge i_clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("valid_pulses", valid_count, push_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter NB_DATA, default 8: operand/result width, range 4..32.
REQ-002 Parameter NB_OP, default 6: opcode width, taken from i_data[NB_OP-1:0]; NB_OP <= NB_DATA.
REQ-003 Parameter DBNC_CYCLES, default 4: consecutive stable samples needed to accept a button level, range 1..255.
REQ-004 One clock; reset is synchronous and active-high; ports named i_clk and i_reset.
REQ-005 i_clk  in  1  system clock, all state updates on rising edge.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_data  in  NB_DATA  switch value captured as operand A, operand B or opcode.
REQ-008 i_A_button / i_B_button / i_OP_button  in  1 each  raw asynchronous-quality pushbuttons.
REQ-009 o_result  out  NB_DATA  registered ALU result.
REQ-010 o_carry / o_overflow / o_zero  out  1 each  registered flags of last executed op.
REQ-011 o_valid  out  1  one-cycle pulse when o_result/flags update.
REQ-012 o_err  out  1  registered; high if last executed opcode unsupported.
REQ-013 o_state  out  3  current FSM state encoding (debug).

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer then a debouncer: debounced level toggles only after DBNC_CYCLES consecutive synchronized samples differing from current level; counter clears on any sample equal to current level.
REQ-015 Each debounced level SHALL produce a one-cycle event pulse on its 0->1 transition only; holding a button yields exactly one event.
REQ-016 FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DONE=4; other encodings SHALL go to WAIT_A.
REQ-017 WAIT_A: A event -> capture i_data into A, go WAIT_B. WAIT_B: B event -> capture B, go WAIT_OP. WAIT_OP: OP event -> capture i_data[NB_OP-1:0], go EXEC.
REQ-018 Events not matching the current state SHALL be ignored (no capture, no transition).
REQ-019 EXEC SHALL last exactly one cycle; on its exit edge result, flags, o_err update, o_valid pulses in the following cycle, state -> DONE.
REQ-020 DONE: outputs held; A event -> capture A, go WAIT_B; B or OP event -> capture that field, go EXEC (re-execute with one new field).
REQ-021 Simultaneous events in one cycle: only the event valid for the current state acts; in DONE priority A > B > OP.
REQ-022 Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011; any other -> result 0, carry/overflow 0, o_err=1.
REQ-023 ADD: NB_DATA+1-bit sum; carry = bit NB_DATA; overflow = signed overflow.
REQ-024 SUB: A-B modulo 2^NB_DATA; carry = 1 iff A < B unsigned (borrow); overflow = signed overflow.
REQ-025 Logic ops and shifts: carry=0, overflow=0.
REQ-026 SRL/SRA shift A right by unsigned B; B >= NB_DATA -> SRL gives 0, SRA gives all copies of A[NB_DATA-1].
REQ-027 o_zero = (result == 0) for every op, including unsupported.
REQ-028 Latency: from OP event cycle to o_valid = 2 cycles; from raw button rise = 2 sync + DBNC_CYCLES + 1 event + 2.

Reset
REQ-029 While i_reset high at an edge: state=WAIT_A, A/B/op regs=0, o_result=0, all flags=0, o_valid=0, o_err=0, debounce counters and levels=0, synchronizers=0.
REQ-030 Reset mid-operation (any state, incl. EXEC) SHALL abort with no o_valid pulse; a button held through reset release SHALL generate one event after debouncing.

Verification
REQ-031 NB_DATA=8, DBNC=4: A=0x7F, B=0x01, OP=100000 -> result 0x80, overflow=1, carry=0, zero=0, one o_valid.
REQ-032 A=0x05, B=0x07, SUB -> result 0xFE, carry=1, overflow=0; then in DONE press B with 0x05 -> result 0x00, zero=1, carry=0.
REQ-033 A=0x90, B=0x09, SRA -> 0xFF; OP=000010 (SRL) from DONE -> 0x00, zero=1.
REQ-034 Button bouncing 1-cycle-high/1-cycle-low for 20 cycles then stable high -> exactly one A capture; B pressed in WAIT_A -> ignored, o_state stays 0.
REQ-035 OP=111111 -> result 0x00, o_err=1, zero=1; next valid op clears o_err.
REQ-036 Assert i_reset during EXEC -> no o_valid, o_result=0, o_state=0 next cycle.
